// File: rtl/sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sched_pkg
//  Purpose  : Shared definitions for the time-slice scheduler. Holds the
//             OS-control opcodes, the scheduler state encoding and the
//             trap-cause values.
//  Revision : 1.0  initial release
// ============================================================================
package sched_pkg;

  // Opcodes of the OS-control instructions the scheduler watches
  localparam logic [4:0] OP_HLT      = 5'b11011;
  localparam logic [4:0] OP_PROGREG  = 5'b11100;
  localparam logic [4:0] OP_SOREG    = 5'b11101;
  localparam logic [4:0] OP_STORE_PC = 5'b11110;
  localparam logic [4:0] OP_JRSO     = 5'b11111;

  // Scheduler states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SELECT    = 3'd1,
    ST_WAIT_DISP = 3'd2,
    ST_RUN       = 3'd3,
    ST_TRAP      = 3'd4,
    ST_SAVE      = 3'd5
  } sched_state_t;

  // Values driven on trap_cause
  localparam logic CAUSE_QUANTUM = 1'b0;
  localparam logic CAUSE_HALT    = 1'b1;

  // True when the instruction retiring this cycle carries the given opcode
  function automatic logic retires(input logic       valid,
                                   input logic [4:0] op,
                                   input logic [4:0] want);
    return valid && (op == want);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational round-robin search. Starting at pid 'start' and
//             wrapping modulo NPROC, returns the first pid whose mask bit is
//             set. 'start' itself is the highest-priority candidate.
//  Ports    : mask  in  NPROC  candidate processes
//             start in  PID_W  first pid examined
//             found out 1      at least one mask bit set
//             pid   out PID_W  selected pid (0 when found=0)
//  Revision : 1.0  initial release
// ============================================================================
module rr_picker
  import sched_pkg::*;
#(
  parameter int NPROC = 4,
  parameter int PID_W = 2
) (
  input  logic [NPROC-1:0] mask,
  input  logic [PID_W-1:0] start,
  output logic             found,
  output logic [PID_W-1:0] pid
);

  int               offs_sum;
  logic [PID_W-1:0] cand;

  // Walk the offsets from farthest to nearest so the nearest hit is the
  // last assignment and therefore wins. Index arithmetic is done in int so
  // the wrap is correct even when NPROC is not a power of two.
  always_comb begin
    found    = 1'b0;
    pid      = '0;
    offs_sum = 0;
    cand     = '0;
    for (int k = NPROC - 1; k >= 0; k--) begin
      offs_sum = int'(start) + k;
      if (offs_sum >= NPROC) begin
        offs_sum = offs_sum - NPROC;
      end
      cand = PID_W'(offs_sum);
      if (mask[cand]) begin
        found = 1'b1;
        pid   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/quantum_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : quantum_scheduler
//  Purpose  : Round-robin time-slice scheduler. Counts instructions retired
//             by the running user process, traps to the OS when the quantum
//             expires or the process halts, and sequences the OS context
//             switch (STORE_PC, SOREG/PROGREG bank swap, JRSO).
//  Ports    : clk          in   1      system clock
//             reset        in   1      synchronous active-high reset
//             instr_valid  in   1      an instruction retires this cycle
//             opcode       in   5      opcode of the retiring instruction
//             io_wait      in   1      IN/OUT stalled; freezes slice count
//             sched_en     in   1      OS enables preemptive scheduling
//             proc_mask    in   NPROC  loaded processes, sampled in IDLE
//             bank_sel     out  1      0 = OS bank, 1 = program bank
//             preempt_req  out  1      force PC to the OS trap vector
//             trap_cause   out  1      0 = quantum expired, 1 = halted
//             cur_pid      out  PID_W  process currently/last running
//             next_pid     out  PID_W  process the OS must dispatch
//             next_valid   out  1      next_pid valid
//             proc_done    out  1      pulse: cur_pid executed HLT
//             all_done     out  1      pulse: no live process remains
//             slice_cnt    out  CNT_W  retirements in current slice
//  Revision : 1.0  initial release
// ============================================================================
module quantum_scheduler
  import sched_pkg::*;
#(
  parameter int QUANTUM = 32,
  parameter int NPROC   = 4,
  parameter int PID_W   = 2,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [4:0]       opcode,
  input  logic             io_wait,
  input  logic             sched_en,
  input  logic [NPROC-1:0] proc_mask,
  output logic             bank_sel,
  output logic             preempt_req,
  output logic             trap_cause,
  output logic [PID_W-1:0] cur_pid,
  output logic [PID_W-1:0] next_pid,
  output logic             next_valid,
  output logic             proc_done,
  output logic             all_done,
  output logic [CNT_W-1:0] slice_cnt
);

  localparam logic [CNT_W-1:0] SLICE_LAST = CNT_W'(QUANTUM - 1);
  localparam logic [PID_W-1:0] PID_LAST   = PID_W'(NPROC - 1);

  sched_state_t     state;
  logic [NPROC-1:0] alive;
  // Set by reset: the very first search begins at pid 0 inclusive rather
  // than after cur_pid.
  logic             first_sel;

  logic [PID_W-1:0] search_start;
  logic             pick_found;
  logic [PID_W-1:0] pick_pid;

  logic ret_hlt;
  logic ret_progreg;
  logic ret_soreg;
  logic ret_store_pc;
  logic ret_jrso;
  logic counts;
  logic slice_full;

  assign ret_hlt      = retires(instr_valid, opcode, OP_HLT);
  assign ret_progreg  = retires(instr_valid, opcode, OP_PROGREG);
  assign ret_soreg    = retires(instr_valid, opcode, OP_SOREG);
  assign ret_store_pc = retires(instr_valid, opcode, OP_STORE_PC);
  assign ret_jrso     = retires(instr_valid, opcode, OP_JRSO);

  // A retirement only advances the slice when the core is not parked on
  // an I/O handshake; the same qualifier gates quantum expiry so I/O waits
  // push the preemption point out.
  assign counts     = instr_valid && !io_wait;
  assign slice_full = (slice_cnt == SLICE_LAST);

  // Search begins at the pid after cur_pid; cur_pid itself is the last
  // candidate, so a lone surviving process is re-dispatched.
  always_comb begin
    if (first_sel || (cur_pid == PID_LAST)) begin
      search_start = '0;
    end else begin
      search_start = cur_pid + PID_W'(1);
    end
  end

  rr_picker #(
    .NPROC (NPROC),
    .PID_W (PID_W)
  ) u_picker (
    .mask  (alive),
    .start (search_start),
    .found (pick_found),
    .pid   (pick_pid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      alive       <= '0;
      first_sel   <= 1'b1;
      bank_sel    <= 1'b0;
      preempt_req <= 1'b0;
      trap_cause  <= 1'b0;
      cur_pid     <= '0;
      next_pid    <= '0;
      next_valid  <= 1'b0;
      proc_done   <= 1'b0;
      all_done    <= 1'b0;
      slice_cnt   <= '0;
    end else begin
      // Pulse outputs default low every cycle
      proc_done <= 1'b0;
      all_done  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (sched_en && (|proc_mask)) begin
            alive <= proc_mask;
            state <= ST_SELECT;
          end
        end

        ST_SELECT: begin
          first_sel <= 1'b0;
          if (pick_found) begin
            next_pid   <= pick_pid;
            next_valid <= 1'b1;
            state      <= ST_WAIT_DISP;
          end else begin
            all_done <= 1'b1;
            state    <= ST_IDLE;
          end
        end

        ST_WAIT_DISP: begin
          // JRSO is honoured even if PROGREG never arrived
          if (ret_progreg) begin
            bank_sel <= 1'b1;
          end else if (ret_jrso) begin
            cur_pid    <= next_pid;
            next_valid <= 1'b0;
            slice_cnt  <= '0;
            state      <= ST_RUN;
          end
        end

        ST_RUN: begin
          // Counter saturates at QUANTUM-1; it never wraps.
          if (counts && !slice_full) begin
            slice_cnt <= slice_cnt + CNT_W'(1);
          end
          // Halt has priority over quantum expiry on the same retirement.
          if (ret_hlt) begin
            proc_done      <= 1'b1;
            alive[cur_pid] <= 1'b0;
            trap_cause     <= CAUSE_HALT;
            preempt_req    <= 1'b1;
            state          <= ST_TRAP;
          end else if (counts && slice_full && sched_en) begin
            trap_cause  <= CAUSE_QUANTUM;
            preempt_req <= 1'b1;
            state       <= ST_TRAP;
          end
        end

        ST_TRAP: begin
          if (ret_store_pc) begin
            preempt_req <= 1'b0;
            state       <= ST_SAVE;
          end
        end

        ST_SAVE: begin
          if (ret_soreg) begin
            bank_sel <= 1'b0;
            state    <= ST_SELECT;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_quantum_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quantum_scheduler
//  Purpose  : Self-checking bench for quantum_scheduler. A table of vectors
//             and hand-written sequences cover the documented scenarios; a
//             randomized phase compares every cycle against a behavioural
//             model of the scheduling rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_quantum_scheduler;
  import sched_pkg::*;

  localparam int Q  = 32;
  localparam int NP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [4:0] opcode;
  logic       io_wait;
  logic       sched_en;
  logic [3:0] proc_mask;
  logic       bank_sel;
  logic       preempt_req;
  logic       trap_cause;
  logic [1:0] cur_pid;
  logic [1:0] next_pid;
  logic       next_valid;
  logic       proc_done;
  logic       all_done;
  logic [5:0] slice_cnt;

  always #5 clk = ~clk;

  quantum_scheduler #(
    .QUANTUM (Q),
    .NPROC   (NP),
    .PID_W   (2),
    .CNT_W   (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .io_wait     (io_wait),
    .sched_en    (sched_en),
    .proc_mask   (proc_mask),
    .bank_sel    (bank_sel),
    .preempt_req (preempt_req),
    .trap_cause  (trap_cause),
    .cur_pid     (cur_pid),
    .next_pid    (next_pid),
    .next_valid  (next_valid),
    .proc_done   (proc_done),
    .all_done    (all_done),
    .slice_cnt   (slice_cnt)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_PICK = 1, P_DISP = 2, P_RUN = 3, P_TRAP = 4, P_SAVE = 5;
  int         m_phase = P_IDLE;
  bit         m_fresh = 1'b1;
  bit [3:0]   m_alive = '0;
  logic       m_bank = 0, m_pre = 0, m_cause = 0, m_nv = 0, m_pdone = 0, m_adone = 0;
  logic [1:0] m_cur = 0, m_next = 0;
  logic [5:0] m_cnt = 0;

  task automatic model_edge();
    logic [5:0] old;
    int         start;
    int         cand;
    bit         got;
    if (reset) begin
      m_phase = P_IDLE; m_fresh = 1'b1; m_alive = '0;
      m_bank = 0; m_pre = 0; m_cause = 0; m_nv = 0; m_pdone = 0; m_adone = 0;
      m_cur = 0; m_next = 0; m_cnt = 0;
      return;
    end
    m_pdone = 0;
    m_adone = 0;
    case (m_phase)
      P_IDLE: if (sched_en && proc_mask != 4'd0) begin
        m_alive = proc_mask;
        m_phase = P_PICK;
      end
      P_PICK: begin
        start   = m_fresh ? 0 : (int'(m_cur) + 1) % NP;
        m_fresh = 1'b0;
        got     = 1'b0;
        for (int off = 0; off < NP; off++) begin
          cand = (start + off) % NP;
          if (!got && m_alive[2'(cand)]) begin
            got    = 1'b1;
            m_next = 2'(cand);
          end
        end
        if (got) begin
          m_nv = 1; m_phase = P_DISP;
        end else begin
          m_adone = 1; m_phase = P_IDLE;
        end
      end
      P_DISP: begin
        if (instr_valid && opcode == OP_PROGREG) m_bank = 1;
        else if (instr_valid && opcode == OP_JRSO) begin
          m_cur = m_next; m_nv = 0; m_cnt = 0; m_phase = P_RUN;
        end
      end
      P_RUN: if (instr_valid) begin
        old = m_cnt;
        if (!io_wait && old < 6'(Q - 1)) m_cnt = old + 6'd1;
        if (opcode == OP_HLT) begin
          m_pdone = 1; m_alive[m_cur] = 1'b0; m_cause = 1; m_pre = 1; m_phase = P_TRAP;
        end else if (!io_wait && old == 6'(Q - 1) && sched_en) begin
          m_cause = 0; m_pre = 1; m_phase = P_TRAP;
        end
      end
      P_TRAP: if (instr_valid && opcode == OP_STORE_PC) begin
        m_pre = 0; m_phase = P_SAVE;
      end
      P_SAVE: if (instr_valid && opcode == OP_SOREG) begin
        m_bank = 0; m_phase = P_PICK;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  // ---------------- helpers ----------------
  function automatic logic [15:0] pack(input logic b, input logic p, input logic c,
                                       input logic [1:0] cu, input logic [1:0] nx,
                                       input logic nv, input logic pd, input logic ad,
                                       input logic [5:0] cn);
    return {b, p, c, cu, nx, nv, pd, ad, cn};
  endfunction

  function automatic logic [15:0] dut_pack();
    return pack(bank_sel, preempt_req, trap_cause, cur_pid, next_pid,
                next_valid, proc_done, all_done, slice_cnt);
  endfunction

  function automatic logic [15:0] model_pack();
    return pack(m_bank, m_pre, m_cause, m_cur, m_next, m_nv, m_pdone, m_adone, m_cnt);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare
  // all outputs 1 ns later.
  task automatic step(input logic r, input logic v, input logic [4:0] op,
                      input logic iw, input logic en, input logic [3:0] m);
    reset = r; instr_valid = v; opcode = op; io_wait = iw; sched_en = en; proc_mask = m;
    @(posedge clk);
    model_edge();
    #1;
    check("model", 32'(dut_pack()), 32'(model_pack()));
  endtask

  logic       en_v;
  logic [3:0] mask_v;
  task automatic ret(input logic [4:0] op);
    step(1'b0, 1'b1, op, 1'b0, en_v, mask_v);
  endtask
  task automatic ret_io(input logic [4:0] op);
    step(1'b0, 1'b1, op, 1'b1, en_v, mask_v);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 1'b0, en_v, mask_v);
  endtask

  localparam logic [4:0] OP_NOP = 5'b00000;

  typedef struct packed {
    logic        rst;
    logic        v;
    logic [4:0]  op;
    logic        iow;
    logic        en;
    logic [3:0]  mask;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [4:0] rop;
    int         r;

    reset = 1'b1; instr_valid = 1'b0; opcode = '0; io_wait = 1'b0;
    sched_en = 1'b0; proc_mask = '0;

    // ---- table: reset, start, select, PROGREG, JRSO ----
    tbl[0] = '{1'b1, 1'b0, OP_NOP,     1'b0, 1'b0, 4'b0000, pack(0,0,0,2'd0,2'd0,0,0,0,6'd0)};
    tbl[1] = '{1'b0, 1'b0, OP_NOP,     1'b0, 1'b1, 4'b0011, pack(0,0,0,2'd0,2'd0,0,0,0,6'd0)};
    tbl[2] = '{1'b0, 1'b0, OP_NOP,     1'b0, 1'b1, 4'b0011, pack(0,0,0,2'd0,2'd0,1,0,0,6'd0)};
    tbl[3] = '{1'b0, 1'b1, OP_PROGREG, 1'b0, 1'b1, 4'b0011, pack(1,0,0,2'd0,2'd0,1,0,0,6'd0)};
    tbl[4] = '{1'b0, 1'b1, OP_JRSO,    1'b0, 1'b1, 4'b0011, pack(1,0,0,2'd0,2'd0,0,0,0,6'd0)};
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].op, tbl[i].iow, tbl[i].en, tbl[i].mask);
      check($sformatf("vec%0d", i), 32'(dut_pack()), 32'(tbl[i].exp));
    end

    en_v = 1'b1; mask_v = 4'b0011;

    // ---- quantum expiry on pid 0 ----
    for (int i = 0; i < Q - 1; i++) ret(OP_NOP);
    check("cnt_before_expiry", 32'(slice_cnt), 32'd31);
    check("no_preempt_yet", 32'(preempt_req), 32'd0);
    ret(OP_NOP);
    check("preempt_after_quantum", 32'(preempt_req), 32'd1);
    check("cause_quantum", 32'(trap_cause), 32'd0);
    check("cnt_saturated", 32'(slice_cnt), 32'd31);

    // ---- context switch to pid 1 ----
    ret(OP_STORE_PC);
    check("store_pc_drops_preempt", 32'(preempt_req), 32'd0);
    ret(OP_SOREG);
    check("soreg_bank_os", 32'(bank_sel), 32'd0);
    idle();
    check("rr_next_pid1", 32'({next_valid, next_pid}), 32'({1'b1, 2'd1}));
    ret(OP_PROGREG);
    ret(OP_JRSO);
    check("dispatch_pid1", 32'({cur_pid, slice_cnt}), 32'({2'd1, 6'd0}));

    // ---- io_wait freezes count, then HLT on the last quantum slot ----
    for (int i = 0; i < 10; i++) ret_io(OP_NOP);
    check("io_wait_frozen", 32'(slice_cnt), 32'd0);
    for (int i = 0; i < Q - 1; i++) ret(OP_NOP);
    check("io_delay_no_preempt", 32'({preempt_req, slice_cnt}), 32'({1'b0, 6'd31}));
    ret(OP_HLT);
    check("hlt_last_slot", 32'({proc_done, trap_cause, preempt_req}), 32'(3'b111));
    idle();
    check("proc_done_single", 32'(proc_done), 32'd0);

    // ---- next select must fall back to pid 0 ----
    ret(OP_STORE_PC);
    ret(OP_SOREG);
    idle();
    check("rr_back_to_pid0", 32'({next_valid, next_pid}), 32'({1'b1, 2'd0}));
    ret(OP_PROGREG);
    ret(OP_JRSO);
    check("dispatch_pid0", 32'(cur_pid), 32'd0);

    // ---- last live process halts -> all_done ----
    mask_v = 4'b0000;
    ret(OP_HLT);
    check("last_halt_done", 32'(proc_done), 32'd1);
    ret(OP_STORE_PC);
    ret(OP_SOREG);
    idle();
    check("all_done_pulse", 32'({all_done, bank_sel, next_valid}), 32'(3'b100));
    idle();
    check("all_done_single", 32'(all_done), 32'd0);
    ret(OP_PROGREG);
    check("idle_ignores_progreg", 32'(bank_sel), 32'd0);

    // ---- reset in WAIT_DISP with bank_sel=1 ----
    mask_v = 4'b1111;
    idle();
    idle();
    check("reselect_pid1", 32'({next_valid, next_pid}), 32'({1'b1, 2'd1}));
    ret(OP_PROGREG);
    check("bank_prog_before_reset", 32'(bank_sel), 32'd1);
    step(1'b1, 1'b0, OP_NOP, 1'b0, en_v, mask_v);
    check("reset_all_zero", 32'(dut_pack()), 32'd0);
    en_v = 1'b0;
    ret(OP_JRSO);
    check("jrso_after_reset_ignored", 32'(dut_pack()), 32'd0);

    // ---- sched_en=0: counter saturates, no preemption, HLT still traps ----
    en_v = 1'b1; mask_v = 4'b0100;
    idle();
    idle();
    check("fresh_select_pid2", 32'({next_valid, next_pid}), 32'({1'b1, 2'd2}));
    ret(OP_PROGREG);
    ret(OP_JRSO);
    en_v = 1'b0;
    for (int i = 0; i < 40; i++) ret(OP_NOP);
    check("sat_no_preempt", 32'({preempt_req, slice_cnt}), 32'({1'b0, 6'd31}));
    ret(OP_HLT);
    check("hlt_traps_without_en", 32'({preempt_req, trap_cause}), 32'(2'b11));

    // ---- randomized phase against the model ----
    step(1'b1, 1'b0, OP_NOP, 1'b0, 1'b0, 4'b0000);
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 31));
      if (r == 0)       rop = OP_HLT;
      else if (r < 5)   rop = OP_PROGREG;
      else if (r < 9)   rop = OP_SOREG;
      else if (r < 13)  rop = OP_STORE_PC;
      else if (r < 17)  rop = OP_JRSO;
      else              rop = 5'($urandom_range(0, 26));
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 9) < 7,
           rop,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) != 0,
           4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
